// File: rtl/imem_load_ctrl_pkg.sv
// imem_load_ctrl_pkg
//   Shared definitions for the instruction-memory loader: instruction bus
//   width, write-enable levels, FSM state encoding and the default
//   end-of-load address and idle-timeout limit.
//   No ports (package).
package imem_load_ctrl_pkg;

    localparam int          INST_W          = 32;
    localparam int          WCNT_W          = 16;
    localparam int          TMO_W           = 24;

    localparam logic        WE_ON           = 1'b1;
    localparam logic        WE_OFF          = 1'b0;

    localparam logic [31:0] END_ADDR_DEF    = 32'hFFFF_FFFC;
    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd1_000_000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// imem_load_ctrl_if
//   Loader write bus and instruction-RAM bus of the loader controller.
//   Signals:
//     ld_addr / ld_data / ld_we   loader word address, data, single-cycle strobe
//     mem_addr / mem_wdata / mem_we   instruction RAM address, write data, enable
//   Modports:
//     master  loader + RAM side (drives ld_*, observes mem_*)
//     slave   controller side (observes ld_*, drives mem_*)
interface imem_load_ctrl_if;
    import imem_load_ctrl_pkg::*;

    logic [INST_W-1:0] ld_addr;
    logic [INST_W-1:0] ld_data;
    logic              ld_we;
    logic [INST_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (
        output ld_addr, ld_data, ld_we,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  ld_addr, ld_data, ld_we,
        output mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/imem_load_ctrl_load_timeout.sv
// load_timeout
//   Idle-cycle counter for the loader. Counts up while i_tick is high,
//   returns to zero on i_clear (clear wins over tick). o_expire is high
//   while the count equals LIMIT-1.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     i_clear      zero the counter
//     i_tick       advance the counter
//     o_expire     count has reached LIMIT-1
module load_timeout
    import imem_load_ctrl_pkg::*;
#(
    parameter logic [TMO_W-1:0] LIMIT = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expire
);

    localparam logic [TMO_W-1:0] TC = LIMIT - TMO_W'(1);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign o_expire = (r_cnt == TC);

endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Boot-time instruction memory loader. Accepts word writes from a loader,
//   forwards them to the instruction RAM one cycle later, and holds the core
//   in reset until the load finishes (end-marker address) or the boot idle
//   timeout expires. Optional checksum: define IMEM_LOAD_CHECKSUM_EN to check
//   the end-marker data against a running XOR of all written words.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     bus             loader + RAM bus (slave modport)
//     i_core_pc       core fetch address, routed to the RAM in RUN
//     o_core_rst_n    core reset, high only in RUN
//     o_load_busy     high in BOOT and LOAD
//     o_load_err      high in ERR
//     o_word_cnt      words written in the current load, saturating
//
//   state | meaning
//   ------+----------------------------------------------------------
//   BOOT  | after reset; waiting for the first loader strobe or timeout
//   LOAD  | accepting words; end-marker finishes, silence times out
//   RUN   | core released, RAM address follows the core PC
//   ERR   | load stalled or checksum bad; only a strobe or reset exits
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter logic [31:0] END_ADDR    = END_ADDR_DEF,
    parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_load_ctrl_if.slave     bus,
    input  logic [INST_W-1:0]   i_core_pc,
    output logic                o_core_rst_n,
    output logic                o_load_busy,
    output logic                o_load_err,
    output logic [WCNT_W-1:0]   o_word_cnt
);

    ld_state_e          r_state;
    logic [INST_W-1:0]  r_addr;
    logic [INST_W-1:0]  r_wdata;
    logic               r_mem_we;
    logic               r_core_rst_n;
    logic               r_busy;
    logic               r_err;
    logic [WCNT_W-1:0]  r_wcnt;

    ld_state_e          w_nxt;
    logic               w_wr;
    logic               w_restart;
    logic               w_is_end;
    logic               w_sum_ok;
    logic               w_tick;
    logic               w_expire;
    logic               w_clear;

    assign w_is_end = (bus.ld_addr == END_ADDR);
    assign w_tick   = (r_state == ST_BOOT) || (r_state == ST_LOAD);
    // Every state change is caused either by a strobe or by expiry, so
    // this also covers "clear on every state change".
    assign w_clear  = bus.ld_we || (w_tick && w_expire);
    // A strobe outside LOAD starts a fresh load.
    assign w_restart = bus.ld_we && (r_state != ST_LOAD);

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [INST_W-1:0] r_xor;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xor <= '0;
        end else if (w_restart) begin
            r_xor <= w_wr ? bus.ld_data : '0;
        end else if (w_wr) begin
            r_xor <= r_xor ^ bus.ld_data;
        end
    end

    assign w_sum_ok = (bus.ld_data == r_xor);
`else
    assign w_sum_ok = 1'b1;
`endif

    load_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_load_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_tick   (w_tick),
        .o_expire (w_expire)
    );

    always_comb begin
        w_nxt = r_state;
        w_wr  = 1'b0;
        case (r_state)
            ST_BOOT: begin
                if (bus.ld_we) begin
                    w_nxt = ST_LOAD;
                    w_wr  = !w_is_end;
                end else if (w_expire) begin
                    w_nxt = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (bus.ld_we) begin
                    if (w_is_end) begin
                        w_nxt = w_sum_ok ? ST_RUN : ST_ERR;
                    end else begin
                        w_wr = 1'b1;
                    end
                end else if (w_expire) begin
                    w_nxt = ST_ERR;
                end
            end
            ST_RUN: begin
                if (bus.ld_we) begin
                    w_nxt = ST_LOAD;
                    w_wr  = !w_is_end;
                end
            end
            ST_ERR: begin
                // Leaving ERR only restarts the load; the strobe's word is
                // not written and the count starts again from zero.
                if (bus.ld_we) begin
                    w_nxt = ST_LOAD;
                end
            end
            default: w_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_we     <= WE_OFF;
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b1;
            r_err        <= 1'b0;
            r_wcnt       <= '0;
        end else begin
            r_state  <= w_nxt;
            r_mem_we <= w_wr ? WE_ON : WE_OFF;
            if (w_wr) begin
                r_addr  <= bus.ld_addr;
                r_wdata <= bus.ld_data;
            end
            if (w_restart) begin
                r_wcnt <= w_wr ? WCNT_W'(1) : '0;
            end else if (w_wr && (r_wcnt != {WCNT_W{1'b1}})) begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
            end
            // Decoded from the next state so the flags line up with it.
            r_core_rst_n <= (w_nxt == ST_RUN);
            r_busy       <= (w_nxt == ST_BOOT) || (w_nxt == ST_LOAD);
            r_err        <= (w_nxt == ST_ERR);
        end
    end

    assign bus.mem_addr  = (r_state == ST_RUN) ? i_core_pc : r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = r_mem_we;
    assign o_core_rst_n  = r_core_rst_n;
    assign o_load_busy   = r_busy;
    assign o_load_err    = r_err;
    assign o_word_cnt    = r_wcnt;

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

    localparam logic [31:0] END_A = 32'hFFFF_FFFC;
    localparam int          TMO   = 16;
    localparam int          M_BOOT = 0, M_LOAD = 1, M_RUN = 2, M_ERR = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] core_pc;
    logic        core_rst_n, load_busy, load_err;
    logic [15:0] word_cnt;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    imem_load_ctrl_if u_if ();

    imem_load_ctrl #(
        .END_ADDR    (END_A),
        .TIMEOUT_CYC (24'd16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (u_if),
        .i_core_pc    (core_pc),
        .o_core_rst_n (core_rst_n),
        .o_load_busy  (load_busy),
        .o_load_err   (load_err),
        .o_word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: mode, idle cycles since last strobe/state change,
    // pending RAM write, last written word, count and XOR.
    int          m_mode;
    int          m_idle;
    bit          m_valid = 1'b0;
    bit          m_pend;
    logic [31:0] m_addr, m_data, m_xor;
    int          m_cnt;

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        m_pend = 1'b1;
        m_addr = a;
        m_data = d;
        m_xor  = m_xor ^ d;
        if (m_cnt < 65535) m_cnt++;
    endtask

    always @(posedge clk) begin
        bit sum_ok;
        m_valid = 1'b1;
        if (!rst_n) begin
            m_mode = M_BOOT; m_idle = 0; m_pend = 1'b0;
            m_addr = '0; m_data = '0; m_xor = '0; m_cnt = 0;
        end else begin
            m_pend = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_ok = (u_if.ld_data == m_xor);
`else
            sum_ok = 1'b1;
`endif
            if (u_if.ld_we) begin
                m_idle = 0;
                if (m_mode == M_LOAD) begin
                    if (u_if.ld_addr == END_A) m_mode = sum_ok ? M_RUN : M_ERR;
                    else m_write(u_if.ld_addr, u_if.ld_data);
                end else if (m_mode == M_ERR) begin
                    m_mode = M_LOAD; m_cnt = 0; m_xor = '0;
                end else begin
                    m_mode = M_LOAD; m_cnt = 0; m_xor = '0;
                    if (u_if.ld_addr != END_A) m_write(u_if.ld_addr, u_if.ld_data);
                end
            end else if (m_mode == M_BOOT || m_mode == M_LOAD) begin
                if (m_idle == TMO - 1) begin
                    m_mode = (m_mode == M_BOOT) ? M_RUN : M_ERR;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("mem_we",     u_if.mem_we, m_pend);
            check("mem_addr",   u_if.mem_addr, (m_mode == M_RUN) ? core_pc : m_addr);
            check("mem_wdata",  u_if.mem_wdata, m_data);
            check("core_rst_n", core_rst_n, m_mode == M_RUN);
            check("load_busy",  load_busy, m_mode == M_BOOT || m_mode == M_LOAD);
            check("load_err",   load_err, m_mode == M_ERR);
            check("word_cnt",   word_cnt, m_cnt[15:0]);
            if (u_if.mem_we === 1'b1) pulses++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] a, input logic [31:0] d);
        u_if.ld_addr = a;
        u_if.ld_data = d;
        u_if.ld_we   = 1'b1;
        cyc();
        u_if.ld_we   = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        core_pc = 32'h0;
        u_if.ld_addr = '0;
        u_if.ld_data = '0;
        u_if.ld_we   = 1'b0;

        // Reset state
        do_reset();
        check("rst_busy", load_busy, 1'b1);
        check("rst_core", core_rst_n, 1'b0);
        check("rst_cnt",  word_cnt, 16'd0);

        // Boot timeout: RUN after exactly 16 cycles
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n++;
            if (core_rst_n) break;
        end
        check("boot_cycles", n, 16);
        core_pc = 32'h0000_1234;
        #1;
        check("run_pc", u_if.mem_addr, 32'h0000_1234);

        // Reload from RUN
        u_if.ld_addr = 32'h8;
        u_if.ld_data = 32'hDEAD_BEEF;
        u_if.ld_we   = 1'b1;
        cyc();
        u_if.ld_we   = 1'b0;
        check("reload_core", core_rst_n, 1'b0);
        check("reload_we",   u_if.mem_we, 1'b1);
        check("reload_cnt",  word_cnt, 16'd1);
        check("reload_addr", u_if.mem_addr, 32'h8);
        cyc();
        check("reload_we_1cyc", u_if.mem_we, 1'b0);
        strobe(END_A, 32'hDEAD_BEEF);
        check("reload_run", core_rst_n, 1'b1);

        // Two-word load then end marker
        do_reset();
        pulses = 0;
        strobe(32'h0, 32'h0000_0013);
        strobe(32'h4, 32'h0010_0093);
        strobe(END_A, 32'h0010_0080);
        check("load_pulses", pulses, 2);
        check("load_cnt",    word_cnt, 16'd2);
        check("load_run",    core_rst_n, 1'b1);

        // LOAD timeout
        do_reset();
        strobe(32'h10, 32'h1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n++;
            if (load_err) break;
        end
        check("tmo_cycles", n, 15);
        check("tmo_err",    load_err, 1'b1);
        check("tmo_core",   core_rst_n, 1'b0);

        // Leave ERR with a strobe
        pulses = 0;
        strobe(32'h20, 32'h5);
        check("errx_busy",   load_busy, 1'b1);
        check("errx_cnt",    word_cnt, 16'd0);
        check("errx_pulses", pulses, 0);
        strobe(END_A, 32'h0);
        check("errx_run", core_rst_n, 1'b1);

        // End-marker data: checksum match / mismatch
        do_reset();
        strobe(32'h0, 32'hA5A5_A5A5);
        strobe(32'h4, 32'h0F0F_0F0F);
        strobe(END_A, 32'hAAAA_AAAA);
        check("sum_good_run", core_rst_n, 1'b1);
        strobe(32'h0, 32'hA5A5_A5A5);
        strobe(32'h4, 32'h0F0F_0F0F);
        strobe(END_A, 32'h0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("sum_bad_err", load_err, 1'b1);
`else
        check("nosum_run", core_rst_n, 1'b1);
`endif

        // Reset during LOAD
        do_reset();
        strobe(32'h0, 32'h1);
        u_if.ld_addr = 32'h4;
        u_if.ld_data = 32'h2;
        u_if.ld_we   = 1'b1;
        rst_n        = 1'b0;
        cyc();
        u_if.ld_we   = 1'b0;
        check("rstl_we",   u_if.mem_we, 1'b0);
        check("rstl_cnt",  word_cnt, 16'd0);
        check("rstl_busy", load_busy, 1'b1);
        rst_n = 1'b1;
        cyc();
        check("rstl_no_write", u_if.mem_we, 1'b0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
